// File: rtl/alu_disp_pkg.sv
// alu_disp_pkg: shared FSM state encoding, unit-select codes and FUN field positions
package alu_disp_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;
    localparam logic [1:0] UNIT_ARITH = 2'b00;
    localparam logic [1:0] UNIT_LOGIC = 2'b01;
    localparam logic [1:0] UNIT_CMP   = 2'b10;
    localparam logic [1:0] UNIT_SHIFT = 2'b11;
    localparam int FUN_SEL_HI = 3;
    localparam int FUN_SEL_LO = 2;
    localparam int FUN_OP_HI  = 1;
    localparam int FUN_OP_LO  = 0;
endpackage

// File: rtl/alu_fun_decoder.sv
// alu_fun_decoder: maps FUN to a one-hot unit enable vector and the unit opcode
//   fun_i [3:0] in : function code (select in [3:2], opcode in [1:0])
//   en_o  [3:0] out: one-hot enable, bit index = unit select
//   op_o  [1:0] out: opcode forwarded to the units
module alu_fun_decoder
    import alu_disp_pkg::*;
(
    input  logic [3:0] fun_i,
    output logic [3:0] en_o,
    output logic [1:0] op_o
);
    assign en_o = 4'b0001 << fun_i[FUN_SEL_HI:FUN_SEL_LO];
    assign op_o = fun_i[FUN_OP_HI:FUN_OP_LO];
endmodule

// File: rtl/alu_op_dispatcher.sv
// alu_op_dispatcher: issues one command to one of four ALU units and returns its result
//   CLK/RST                  : clock, synchronous active-high reset
//   cmd_valid/cmd_ready      : command handshake; cmd_A, cmd_B operands, cmd_FUN function
//   unit_A/unit_B/unit_OP    : shared operand/opcode bus to all units
//   *_enable                 : one-cycle start pulse to the selected unit
//   *_out/*_flag             : registered unit results and result-valid flags
//   res_valid/res_ready      : result handshake; res_data, res_unit, res_err payload
// Optional: define ALU_DISP_TIMEOUT_EN to add a WAIT watchdog of timeout_cycles cycles.
module alu_op_dispatcher
    import alu_disp_pkg::*;
#(
    parameter int in_width       = 16,
    parameter int out_width      = 16,
    parameter int timeout_cycles = 15
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [in_width-1:0]  cmd_A,
    input  logic [in_width-1:0]  cmd_B,
    input  logic [3:0]           cmd_FUN,
    output logic [in_width-1:0]  unit_A,
    output logic [in_width-1:0]  unit_B,
    output logic [1:0]           unit_OP,
    output logic                 arith_enable,
    output logic                 logic_enable,
    output logic                 cmp_enable,
    output logic                 shift_enable,
    input  logic [out_width-1:0] arith_out,
    input  logic [out_width-1:0] logic_out,
    input  logic [out_width-1:0] cmp_out,
    input  logic [out_width-1:0] shift_out,
    input  logic                 arith_flag,
    input  logic                 logic_flag,
    input  logic                 cmp_flag,
    input  logic                 shift_flag,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [out_width-1:0] res_data,
    output logic [1:0]           res_unit,
    output logic                 res_err
);
    state_t               state_q;
    logic [in_width-1:0]  a_q, b_q;
    logic [3:0]           fun_q;
    logic [out_width-1:0] data_q;
    logic [1:0]           unit_q;
    logic [3:0]           en_dec, en, flags;
    logic [1:0]           sel;
    logic                 sel_flag;
    logic [out_width-1:0] sel_out;

    alu_fun_decoder u_dec (.fun_i(fun_q), .en_o(en_dec), .op_o(unit_OP));

    assign sel      = fun_q[FUN_SEL_HI:FUN_SEL_LO];
    assign flags    = {shift_flag, cmp_flag, logic_flag, arith_flag};
    // only the selected unit's flag can advance WAIT; others are ignored
    assign sel_flag = flags[sel];

    always_comb begin
        sel_out = sel == UNIT_ARITH ? arith_out :
                  sel == UNIT_LOGIC ? logic_out :
                  sel == UNIT_CMP   ? cmp_out   : shift_out;
    end

    assign en           = state_q == ISSUE ? en_dec : 4'b0000;
    assign arith_enable = en[UNIT_ARITH];
    assign logic_enable = en[UNIT_LOGIC];
    assign cmp_enable   = en[UNIT_CMP];
    assign shift_enable = en[UNIT_SHIFT];
    assign cmd_ready    = state_q == IDLE;
    assign res_valid    = state_q == RESP;
    assign unit_A       = a_q;
    assign unit_B       = b_q;
    assign res_data     = data_q;
    assign res_unit     = unit_q;

`ifdef ALU_DISP_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    assign res_err = err_q;
`else
    assign res_err = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            fun_q   <= '0;
            data_q  <= '0;
            unit_q  <= '0;
`ifdef ALU_DISP_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    a_q     <= cmd_A;
                    b_q     <= cmd_B;
                    fun_q   <= cmd_FUN;
                    state_q <= ISSUE;
                end
                ISSUE: begin
                    state_q <= WAIT;
`ifdef ALU_DISP_TIMEOUT_EN
                    cnt_q   <= '0;
`endif
                end
                WAIT: if (sel_flag) begin
                    data_q  <= sel_out;
                    unit_q  <= sel;
                    state_q <= RESP;
`ifdef ALU_DISP_TIMEOUT_EN
                    err_q   <= 1'b0;
                end else if (cnt_q == CW'(timeout_cycles - 1)) begin
                    // this is the timeout_cycles-th WAIT cycle without the flag
                    data_q  <= '0;
                    unit_q  <= sel;
                    err_q   <= 1'b1;
                    state_q <= RESP;
                end else begin
                    cnt_q   <= cnt_q + 1'b1;
`endif
                end
                RESP: if (res_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_op_dispatcher.sv
// tb_alu_op_dispatcher: directed self-checking bench with simple registered unit models
module tb_alu_op_dispatcher;
    logic        CLK = 1'b0;
    logic        RST, cmd_valid, cmd_ready, res_valid, res_ready, res_err;
    logic [15:0] cmd_A, cmd_B, unit_A, unit_B, res_data;
    logic [15:0] arith_out, logic_out, cmp_out, shift_out;
    logic [3:0]  cmd_FUN, en;
    logic [1:0]  unit_OP, res_unit;
    logic        arith_enable, logic_enable, cmp_enable, shift_enable;
    logic        arith_flag, logic_flag, cmp_flag, shift_flag;
    logic        auto_q, inj_logic, inj_shift, inj_cmp;
    int          checks = 0;
    int          errors = 0;

    alu_op_dispatcher #(.in_width(16), .out_width(16), .timeout_cycles(15)) dut (
        .CLK(CLK), .RST(RST),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_FUN(cmd_FUN),
        .unit_A(unit_A), .unit_B(unit_B), .unit_OP(unit_OP),
        .arith_enable(arith_enable), .logic_enable(logic_enable),
        .cmp_enable(cmp_enable), .shift_enable(shift_enable),
        .arith_out(arith_out), .logic_out(logic_out), .cmp_out(cmp_out), .shift_out(shift_out),
        .arith_flag(arith_flag), .logic_flag(logic_flag), .cmp_flag(cmp_flag), .shift_flag(shift_flag),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_unit(res_unit), .res_err(res_err)
    );

    always #5 CLK = ~CLK;

    assign en = {shift_enable, cmp_enable, logic_enable, arith_enable};

    // unit models: results registered from the bus, flag one cycle after enable
    always @(posedge CLK) begin
        arith_flag <= arith_enable & auto_q;
        logic_flag <= (logic_enable & auto_q) | inj_logic;
        cmp_flag   <= (cmp_enable & auto_q) | inj_cmp;
        shift_flag <= (shift_enable & auto_q) | inj_shift;
        arith_out  <= unit_OP == 2'd0 ? unit_A + unit_B : unit_A - unit_B;
        logic_out  <= unit_OP == 2'd0 ? unit_A & unit_B :
                      unit_OP == 2'd1 ? unit_A | unit_B :
                      unit_OP == 2'd2 ? unit_A ^ unit_B : ~(unit_A | unit_B);
        cmp_out    <= {15'd0, unit_A < unit_B};
        shift_out  <= unit_OP == 2'd0 ? unit_A << unit_B[3:0] : unit_A >> unit_B[3:0];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge CLK);
        check("onehot", 32'($countones(en) <= 1), 32'd1);
    endtask

    task automatic send(input logic [3:0] fun, input logic [15:0] a, input logic [15:0] b);
        check("send_rdy", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_FUN   = fun;
        cmd_A     = a;
        cmd_B     = b;
        step();
        cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end

    initial begin
        RST = 1'b1; cmd_valid = 1'b0; cmd_A = '0; cmd_B = '0; cmd_FUN = '0; res_ready = 1'b0;
        auto_q = 1'b1; inj_logic = 1'b0; inj_shift = 1'b0; inj_cmp = 1'b0;
        repeat (2) @(negedge CLK);
        check("rst_rdy", 32'(cmd_ready), 32'd1);
        check("rst_vld", 32'(res_valid), 32'd0);
        check("rst_en", 32'(en), 32'd0);
        check("rst_a", 32'(unit_A), 32'd0);
        check("rst_b", 32'(unit_B), 32'd0);
        check("rst_op", 32'(unit_OP), 32'd0);
        check("rst_data", 32'(res_data), 32'd0);
        check("rst_unit", 32'(res_unit), 32'd0);
        check("rst_err", 32'(res_err), 32'd0);
        RST = 1'b0;

        // logic AND, minimum latency
        send(4'b0100, 16'h00FF, 16'h0F0F);
        check("t1_en", 32'(en), 32'h2);
        check("t1_op", 32'(unit_OP), 32'd0);
        check("t1_a", 32'(unit_A), 32'h00FF);
        check("t1_rdy", 32'(cmd_ready), 32'd0);
        check("t1_vld_issue", 32'(res_valid), 32'd0);
        step();
        check("t1_en_wait", 32'(en), 32'd0);
        check("t1_b_hold", 32'(unit_B), 32'h0F0F);
        check("t1_vld_wait", 32'(res_valid), 32'd0);
        step();
        check("t1_vld", 32'(res_valid), 32'd1);
        check("t1_data", 32'(res_data), 32'h000F);
        check("t1_unit", 32'(res_unit), 32'd1);
        check("t1_err", 32'(res_err), 32'd0);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t1_idle_vld", 32'(res_valid), 32'd0);
        check("t1_idle_rdy", 32'(cmd_ready), 32'd1);

        // logic NOR with res_ready stalled
        send(4'b0111, 16'hF000, 16'h0F00);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            check("t2_vld", 32'(res_valid), 32'd1);
            check("t2_data", 32'(res_data), 32'h00FF);
            check("t2_rdy", 32'(cmd_ready), 32'd0);
            step();
        end
        check("t2_vld_held", 32'(res_valid), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t2_idle", 32'(cmd_ready), 32'd1);
        check("t2_vld_drop", 32'(res_valid), 32'd0);

        // back-to-back: arith add then shift left, 4-cycle period
        res_ready = 1'b1;
        cmd_valid = 1'b1; cmd_FUN = 4'b0000; cmd_A = 16'd3; cmd_B = 16'd4;
        check("t3_rdy0", 32'(cmd_ready), 32'd1);
        step();
        cmd_FUN = 4'b1100; cmd_A = 16'd1; cmd_B = 16'd4;
        check("t3_en1", 32'(en), 32'h1);
        step();
        check("t3_rdy_wait", 32'(cmd_ready), 32'd0);
        step();
        check("t3_vld1", 32'(res_valid), 32'd1);
        check("t3_data1", 32'(res_data), 32'd7);
        check("t3_unit1", 32'(res_unit), 32'd0);
        step();
        check("t3_rdy4", 32'(cmd_ready), 32'd1);
        step();
        cmd_valid = 1'b0;
        check("t3_en2", 32'(en), 32'h8);
        check("t3_a2", 32'(unit_A), 32'd1);
        step();
        step();
        check("t3_vld2", 32'(res_valid), 32'd1);
        check("t3_data2", 32'(res_data), 32'h0010);
        check("t3_unit2", 32'(res_unit), 32'd3);
        step();
        check("t3_idle", 32'(cmd_ready), 32'd1);
        res_ready = 1'b0;

        // non-selected flag ignored, capture on late logic flag
        auto_q = 1'b0;
        send(4'b0101, 16'h1200, 16'h0034);
        step();
        inj_shift = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t4_ignore", 32'(res_valid), 32'd0);
        end
        inj_shift = 1'b0;
        inj_logic = 1'b1;
        step();
        inj_logic = 1'b0;
        check("t4_pre", 32'(res_valid), 32'd0);
        step();
        check("t4_vld", 32'(res_valid), 32'd1);
        check("t4_data", 32'(res_data), 32'h1234);
        check("t4_unit", 32'(res_unit), 32'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // reset during WAIT, late flag ignored
        send(4'b1000, 16'd1, 16'd2);
        step();
        step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        check("t5_rdy", 32'(cmd_ready), 32'd1);
        check("t5_vld", 32'(res_valid), 32'd0);
        check("t5_en", 32'(en), 32'd0);
        check("t5_a", 32'(unit_A), 32'd0);
        check("t5_b", 32'(unit_B), 32'd0);
        check("t5_op", 32'(unit_OP), 32'd0);
        check("t5_data", 32'(res_data), 32'd0);
        check("t5_unit", 32'(res_unit), 32'd0);
        inj_cmp = 1'b1;
        step();
        inj_cmp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_late_vld", 32'(res_valid), 32'd0);
            check("t5_late_rdy", 32'(cmd_ready), 32'd1);
        end

`ifdef ALU_DISP_TIMEOUT_EN
        // watchdog: cmp flag never arrives
        send(4'b1000, 16'd5, 16'd3);
        for (int i = 0; i < 15; i++) begin
            step();
            check("t6_wait", 32'(res_valid), 32'd0);
        end
        step();
        check("t6_vld", 32'(res_valid), 32'd1);
        check("t6_err", 32'(res_err), 32'd1);
        check("t6_data", 32'(res_data), 32'd0);
        check("t6_unit", 32'(res_unit), 32'd2);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        check("t6_idle", 32'(cmd_ready), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_op_dispatcher.md
ALU_OP_DISPATCHER -- requirements
Module: alu_op_dispatcher

Interface
REQ-001 SHALL have parameter in_width, default 16, operand width.
REQ-002 SHALL have parameter out_width, default 16, result width.
REQ-003 SHALL have parameter timeout_cycles, default 15, WAIT-state watchdog limit, used only under ALU_DISP_TIMEOUT_EN.
REQ-004 SHALL have port CLK  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-006 SHALL have ports cmd_valid input 1, cmd_ready output 1, command handshake.
REQ-007 SHALL have ports cmd_A and cmd_B input in_width, operands; cmd_FUN input 4, function code.
REQ-008 SHALL have ports unit_A and unit_B output in_width, unit_OP output 2, shared operand/opcode bus to all units.
REQ-009 SHALL have ports arith_enable, logic_enable, cmp_enable, shift_enable, output 1 each, per-unit enables.
REQ-010 SHALL have ports arith_out, logic_out, cmp_out, shift_out, input out_width each, registered unit results.
REQ-011 SHALL have ports arith_flag, logic_flag, cmp_flag, shift_flag, input 1 each, per-unit result-valid flags.
REQ-012 SHALL have ports res_valid output 1, res_ready input 1, result handshake.
REQ-013 SHALL have ports res_data output out_width, res_unit output 2, res_err output 1, result payload.

Function
REQ-014 SHALL decode cmd_FUN[3:2] as unit select: 00 arith, 01 logic, 10 cmp, 11 shift; cmd_FUN[1:0] SHALL drive unit_OP.
REQ-015 SHALL implement FSM IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
REQ-016 IDLE: cmd_ready=1; on cmd_valid&&cmd_ready, SHALL latch cmd_A, cmd_B, cmd_FUN and go ISSUE; cmd_ready=0 in every other state.
REQ-017 ISSUE: exactly one selected enable SHALL be 1 for exactly one cycle, with latched operands/opcode on unit_A/unit_B/unit_OP; next state WAIT.
REQ-018 WAIT: all enables 0; unit_A/unit_B/unit_OP SHALL hold latched values; when selected unit's flag=1, SHALL capture that unit's out into res_data, set res_unit=select, res_err=0, go RESP.
REQ-019 Flags/outputs of non-selected units SHALL be ignored.
REQ-020 RESP: res_valid=1 with res_data/res_unit/res_err stable until res_valid&&res_ready; then IDLE; res_valid SHALL NOT drop without handshake.
REQ-021 Minimum latency: res_valid SHALL rise on the second rising edge after the accepting edge when the flag is 1 in WAIT's first cycle; minimum command period 4 cycles with res_ready held 1.
REQ-022 res_data, res_unit, res_err SHALL be registered outputs; cmd_ready and enables SHALL decode from registered state only.

Reset
REQ-023 RST=1 at a rising edge SHALL force IDLE from any state, discarding any in-flight command.
REQ-024 After reset: cmd_ready=1, res_valid=0, all enables 0, unit_A=unit_B=0, unit_OP=0, res_data=0, res_unit=0, res_err=0, watchdog count 0.

Configuration
REQ-025 With ALU_DISP_TIMEOUT_EN defined, a counter SHALL increment each WAIT cycle; if it reaches timeout_cycles without the selected flag, SHALL go RESP with res_data=0, res_err=1; counter clears on WAIT entry.
REQ-026 Without ALU_DISP_TIMEOUT_EN, WAIT SHALL persist until the selected flag; res_err SHALL be constant 0; no counter logic present.

Structure
REQ-027 Package alu_disp_pkg SHALL hold state encoding (IDLE, ISSUE, WAIT, RESP), unit-select constants (UNIT_ARITH=00, UNIT_LOGIC=01, UNIT_CMP=10, UNIT_SHIFT=11), FUN field positions.
REQ-028 Combinational sub-module alu_fun_decoder SHALL map 4-bit FUN to one-hot 4-bit enable vector and 2-bit unit_OP.

Verification
REQ-029 Reset then cmd A=0x00FF, B=0x0F0F, FUN=0100, logic model -> logic_enable 1 cycle with unit_OP=00; res_data=0x000F, res_unit=01, res_err=0; res_valid 2 edges after accept.
REQ-030 FUN=0111, A=0xF000, B=0x0F00, res_ready held 0 for 5 cycles -> res_data=0x00FF stable and res_valid held 5 cycles; cmd_ready=0 throughout; IDLE after handshake.
REQ-031 Back-to-back: cmd_valid held 1 with two commands, res_ready=1 -> second accepted exactly 4 cycles after first; only one enable ever high per cycle.
REQ-032 RST pulsed during WAIT -> next cycle IDLE, all outputs at reset values, late flag ignored, no res_valid.
REQ-033 ALU_DISP_TIMEOUT_EN, timeout_cycles=15, FUN=1000, cmp_flag never asserted -> RESP after 15 WAIT cycles with res_data=0x0000, res_err=1, res_unit=10.
REQ-034 Non-selected unit flag asserted in WAIT (shift_flag=1 with logic selected) -> ignored; capture only on logic_flag.
